full_adder: RTL and testbench

//   1-bit full adder: sum = a^b^cin, carry = majority(a,b,cin).
//   sum/carry are purely combinational and independent of clk/rst.
//   An optional registered copy with a valid flag and a saturating

---
 rtl/fa_pkg.sv | 12 +
 rtl/full_adder_half_adder.sv | 19 +
 rtl/full_adder.sv | 81 ++++++++
 tb/tb_full_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// -----------------------------------------------------------------------------
// fa_pkg
// Shared constants for the full_adder leaf cell.
//   CNT_W_DEFAULT : default width of the carry-event counter
//   CNT_MAX       : saturation value of a counter at the default width
// -----------------------------------------------------------------------------
package fa_pkg;

    localparam int CNT_W_DEFAULT = 8;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = {CNT_W_DEFAULT{1'b1}};

endpackage : fa_pkg

// File: rtl/full_adder_half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Purely combinational 1-bit half adder, building block of full_adder.
// Ports:
//   x, y : input  bits to add
//   s    : output sum   (x ^ y)
//   c    : output carry (x & y)
// -----------------------------------------------------------------------------
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule : half_adder

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// 1-bit full adder leaf cell with a zero-latency combinational result and an
// optional registered copy (valid flag plus saturating carry-event counter)
// for pipelined datapaths and debug.
// Ports:
//   clk       : input  rising-edge clock, registered path only
//   rst       : input  synchronous active-high reset
//   a, b      : input  addend bits
//   cin       : input  carry in
//   in_valid  : input  qualifies a/b/cin for the registered path
//   sum       : output combinational sum
//   carry     : output combinational carry out
//   sum_q     : output registered sum
//   carry_q   : output registered carry
//   out_valid : output sum_q/carry_q hold valid data
//   carry_cnt : output number of valid cycles with carry=1, saturating
// -----------------------------------------------------------------------------
module full_adder
    import fa_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             sum,
    output logic             carry,
    output logic             sum_q,
    output logic             carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    // The combinational path never touches clk/rst/in_valid, so it stays
    // correct even when the registered side is left unclocked.
    half_adder ha0 (
        .x (a),
        .y (b),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder ha1 (
        .x (ha0_s),
        .y (cin),
        .s (sum),
        .c (ha1_c)
    );

    assign carry = ha0_c | ha1_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= 1'b0;
            carry_q   <= 1'b0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
                // Saturate rather than wrap so a long run never reads as few events.
                if (carry && (carry_cnt != CNT_SAT)) begin
                    carry_cnt <= carry_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule : full_adder

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk;
    logic rst;
    logic a, b, cin, in_valid;

    logic       sum8, carry8, sum_q8, carry_q8, out_valid8;
    logic [7:0] cnt8;
    logic       sum2, carry2, sum_q2, carry_q2, out_valid2;
    logic [1:0] cnt2;

    full_adder #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
        .out_valid(out_valid8), .carry_cnt(cnt8)
    );

    full_adder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
        .sum(sum2), .carry(carry2), .sum_q(sum_q2), .carry_q(carry_q2),
        .out_valid(out_valid2), .carry_cnt(cnt2)
    );

    typedef struct {
        logic sum;
        logic carry;
        logic sum_q;
        logic carry_q;
        logic out_valid;
        int   cnt8;
        int   cnt2;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: what the registered outputs must show after the
    // next rising edge, derived from plain arithmetic on the inputs.
    logic m_sum_q, m_carry_q, m_valid;
    int   m_cnt8, m_cnt2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // One clocked transaction: drive at the falling edge, push the model's
    // expectation for the state visible after the following rising edge.
    task automatic step(input logic r, input logic v, input logic ia, input logic ib, input logic ic);
        int   total;
        exp_t e;
        @(negedge clk);
        rst = r; in_valid = v; a = ia; b = ib; cin = ic;
        total = int'(ia) + int'(ib) + int'(ic);
        e.sum   = logic'(total % 2);
        e.carry = logic'(total / 2);
        if (r) begin
            m_sum_q = 1'b0; m_carry_q = 1'b0; m_valid = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_valid = v;
            if (v) begin
                m_sum_q   = e.sum;
                m_carry_q = e.carry;
                if (e.carry) begin
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
                end
            end
        end
        e.sum_q = m_sum_q; e.carry_q = m_carry_q; e.out_valid = m_valid;
        e.cnt8 = m_cnt8; e.cnt2 = m_cnt2;
        exp_q.push_back(e);
    endtask

    task automatic rand_step(input logic r);
        step(r, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    endtask

    // Monitor: compares the DUT against the oldest pending expectation just
    // after each rising edge, independent of the stimulus process.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum",        32'(sum8),       32'(e.sum));
            chk("carry",      32'(carry8),     32'(e.carry));
            chk("sum_q",      32'(sum_q8),     32'(e.sum_q));
            chk("carry_q",    32'(carry_q8),   32'(e.carry_q));
            chk("out_valid",  32'(out_valid8), 32'(e.out_valid));
            chk("carry_cnt8", 32'(cnt8),       32'(e.cnt8));
            chk("carry_cnt2", 32'(cnt2),       32'(e.cnt2));
            chk("sum_q_w2",   32'(sum_q2),     32'(e.sum_q));
            chk("valid_w2",   32'(out_valid2), 32'(e.out_valid));
        end
    end

    initial begin
        logic [2:0] abc;
        int total;
        a = 1'b0; b = 1'b0; cin = 1'b0; in_valid = 1'b0;
        m_sum_q = 1'b0; m_carry_q = 1'b0; m_valid = 1'b0; m_cnt8 = 0; m_cnt2 = 0;

        // Combinational path with clk and rst left undriven.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            a = abc[2]; b = abc[1]; cin = abc[0];
            total = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
            #4;
            chk("comb_sum",   32'(sum8),   32'(total % 2));
            chk("comb_carry", 32'(carry8), 32'(total / 2));
            #1;
        end
        a = 1'bx; b = 1'b0; cin = 1'b0;
        #4;
        chk("x_prop_sum", 32'(sum8), 32'(1'bx));
        #1;
        a = 1'b0;

        clk = 1'b0;
        fork
            forever #5 clk = ~clk;
        join_none

        // Reset held with valid 111 pending.
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        // Single valid 011 then idle: data held, valid drops.
        step(0, 1, 0, 1, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        // Saturation of the 2-bit counter.
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 1, 1, 1, 1);
        // Randomized traffic.
        step(1, 0, 0, 0, 0);
        repeat (1000) rand_step(1'b0);
        // Random traffic with occasional mid-stream reset pulses.
        for (int i = 0; i < 300; i++) begin
            rand_step(logic'(($urandom_range(0, 39)) == 0));
        end
        step(1, 1, 1, 1, 1);
        repeat (5) step(0, 1, 1, 1, 1);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule : tb_full_adder
